// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronized rx, mid-bit sampling FSM, and a
// one-byte holding register with data_valid/data_ready handshake.
module uart_receiver #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       data_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int BIT_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT = BIT_TIME / 2;
  localparam logic [15:0] BIT_LAST  = 16'(BIT_TIME - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        rx_meta_q, rx_s_q;
  logic        load;

  // Synchronizer flops reset high so a released reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    load    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s_q;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) load   = 1'b1;
          else        ferr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh byte wins over a simultaneous acknowledge and is not an overrun then.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ovr_d   = valid_q && !data_ready;
    end else if (data_ready) begin
      valid_d = 1'b0;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit, with a per-cycle
// reference model driven by frame-level timing and literal spot checks.
module tb_uart_receiver;
  localparam int BT = 16;
  // Edge offset from the first clock seeing a start bit to the stop-sample edge:
  // 2 sync/IDLE + HALF_BIT + 8*BT data + BT stop.
  localparam int STOP_EDGE = 2 + BT / 2 + 8 * BT + BT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, frame_error, overrun, busy;

  uart_receiver #(.BAUD_RATE(10), .CLOCK_FREQ(160)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_ready(data_ready),
    .data_out(data_out), .data_valid(data_valid), .frame_error(frame_error),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_ferr = 0;
  int n_ovr = 0;

  int         ev_edge[$];
  logic [7:0] ev_byte[$];
  bit         ev_stop[$];
  int         bz_lo[$];
  int         bz_hi[$];

  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: each queued frame resolves at its stop-sample edge.
  always @(posedge clk) begin
    cyc++;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (!rst_n) begin
      ev_edge.delete(); ev_byte.delete(); ev_stop.delete();
      bz_lo.delete(); bz_hi.delete();
      m_data  = 8'h00;
      m_valid = 1'b0;
    end else if (ev_edge.size() > 0 && ev_edge[0] == cyc) begin
      if (ev_stop[0]) begin
        m_ovr   = m_valid && !data_ready;
        m_data  = ev_byte[0];
        m_valid = 1'b1;
      end else begin
        m_ferr = 1'b1;
      end
      void'(ev_edge.pop_front()); void'(ev_byte.pop_front()); void'(ev_stop.pop_front());
    end else if (data_ready) begin
      m_valid = 1'b0;
    end
    m_busy = 1'b0;
    foreach (bz_lo[i]) if (cyc >= bz_lo[i] && cyc < bz_hi[i]) m_busy = 1'b1;
    #1;
    if (rst_n) begin
      chk("data_out", data_out, m_data);
      chk("data_valid", data_valid, m_valid);
      chk("frame_error", frame_error, m_ferr);
      chk("overrun", overrun, m_ovr);
      chk("busy", busy, m_busy);
      if (frame_error) n_ferr++;
      if (overrun) n_ovr++;
    end
  end

  // All driver tasks start and end on a falling edge.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    int s;
    s = cyc + 1;
    ev_edge.push_back(s + STOP_EDGE); ev_byte.push_back(b); ev_stop.push_back(stop);
    bz_lo.push_back(s + 2); bz_hi.push_back(s + STOP_EDGE);
    // A low stop bit leaves the line low into IDLE: a false start rejected at half-bit.
    if (!stop) begin
      bz_lo.push_back(s + STOP_EDGE + 1); bz_hi.push_back(s + STOP_EDGE + 1 + 8);
    end
    rx = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BT) @(negedge clk);
    end
    rx = stop;
    repeat (BT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack();
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk("rst data_out", data_out, 8'h00);
    chk("rst data_valid", data_valid, 1'b0);
    chk("rst frame_error", frame_error, 1'b0);
    chk("rst overrun", overrun, 1'b0);
    chk("rst busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(5);

    send_frame(8'hA5, 1'b1);
    idle(4);
    chk("A5 data", data_out, 8'hA5);
    chk("A5 valid", data_valid, 1'b1);
    ack();
    @(negedge clk);
    chk("A5 valid after ready", data_valid, 1'b0);
    chk("A5 no ferr", n_ferr, 0);
    chk("A5 no ovr", n_ovr, 0);
    ack();
    chk("ready while empty", data_valid, 1'b0);

    s = cyc + 1;
    bz_lo.push_back(s + 2); bz_hi.push_back(s + 2 + BT / 2);
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(20);
    chk("glitch busy", busy, 1'b0);
    chk("glitch data", data_out, 8'hA5);
    chk("glitch valid", data_valid, 1'b0);

    send_frame(8'h3C, 1'b0);
    idle(20);
    chk("3C ferr count", n_ferr, 1);
    chk("3C valid", data_valid, 1'b0);
    chk("3C data", data_out, 8'hA5);

    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    chk("22 data", data_out, 8'h22);
    chk("22 ovr count", n_ovr, 1);
    chk("22 valid", data_valid, 1'b1);

    s = cyc + 1;
    bz_lo.push_back(s + 2); bz_hi.push_back(32'h3fffffff);
    rx = 1'b0;
    idle(BT);
    rx = 1'b1;
    idle(3 * BT + BT / 2);
    rst_n = 1'b0;
    idle(3);
    chk("midrst data", data_out, 8'h00);
    chk("midrst valid", data_valid, 1'b0);
    chk("midrst busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(5);
    chk("post-rst busy", busy, 1'b0);
    send_frame(8'h5A, 1'b1);
    idle(4);
    chk("5A data", data_out, 8'h5A);
    chk("5A valid", data_valid, 1'b1);
    chk("5A ovr count", n_ovr, 1);

    ack();
    send_frame(8'h00, 1'b1);
    idle(4);
    chk("00 data", data_out, 8'h00);
    chk("00 valid", data_valid, 1'b1);
    ack();
    send_frame(8'hFF, 1'b1);
    idle(4);
    chk("FF data", data_out, 8'hFF);
    chk("FF valid", data_valid, 1'b1);
    chk("final ferr count", n_ferr, 1);
    chk("final ovr count", n_ovr, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001: Parameter BAUD_RATE, default 9600, serial bit rate in bits/s.
REQ-002: Parameter CLOCK_FREQ, default 50000000, clk frequency in Hz.
REQ-003: Local constant BIT_TIME SHALL equal CLOCK_FREQ / BAUD_RATE (integer division); HALF_BIT SHALL equal BIT_TIME / 2.
REQ-004: clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-005: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006: rx  input  1  UART receive line, asynchronous to clk, idle high.
REQ-007: data_out  output  8  last correctly framed received byte.
REQ-008: data_valid  output  1  high while data_out holds an unconsumed byte.
REQ-009: data_ready  input  1  consumer acknowledge; clears data_valid.
REQ-010: frame_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-011: overrun  output  1  one-cycle pulse, new byte completed while data_valid still high.
REQ-012: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013: Frame format SHALL be 8N1: start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-014: rx SHALL pass through a two-flop synchronizer; all FSM decisions SHALL use the synchronized value rx_s only.
REQ-015: The FSM SHALL have states IDLE, START, DATA, STOP; bit counter 0..7, clock counter at least 16 bits wide.
REQ-016: IDLE: when rx_s == 0, go to START with clock_count = 0; otherwise remain.
REQ-017: START: when clock_count == HALF_BIT-1, if rx_s == 0 go to DATA with clock_count = 0 and bit_index = 0; else (glitch) return to IDLE with no output activity.
REQ-018: DATA: when clock_count == BIT_TIME-1, shift_reg[bit_index] <= rx_s and clock_count <= 0; after bit_index 7 is sampled go to STOP; otherwise increment bit_index.
REQ-019: STOP: when clock_count == BIT_TIME-1, sample rx_s and return to IDLE in the same cycle.
REQ-020: Stop sample 1: data_out <= shift_reg and data_valid <= 1 on the next edge; if data_valid was already high and not being cleared that cycle, overrun SHALL pulse for one cycle and data_out SHALL be overwritten.
REQ-021: Stop sample 0: frame_error SHALL pulse for one cycle; data_out and data_valid SHALL remain unchanged.
REQ-022: In all other states clock_count SHALL increment by 1 each cycle.
REQ-023: data_valid SHALL clear on the edge after data_ready == 1 while data_valid == 1; a same-cycle new-byte load SHALL take priority (data_valid stays 1, no overrun).
REQ-024: data_ready while data_valid == 0 SHALL have no effect.
REQ-025: Because of the mid-bit stop sample, the receiver SHALL accept a new start bit HALF_BIT cycles after the nominal stop-bit centre, so back-to-back frames are received without loss.
REQ-026: busy SHALL be combinationally (state != IDLE).

Reset
REQ-027: While rst_n == 0: state = IDLE, clock_count = 0, bit_index = 0, synchronizer flops = 1, data_out = 8'h00, data_valid = 0, frame_error = 0, overrun = 0.
REQ-028: Reset asserted mid-frame SHALL abort the frame with no data_valid, frame_error or overrun; after release the FSM SHALL wait for rx_s high-to-low before starting.

Verification (CLOCK_FREQ=160, BAUD_RATE=10, BIT_TIME=16)
REQ-029: Send 8'hA5 with correct framing, then assert data_ready one cycle -> data_out = 8'hA5, data_valid = 1 until the ready cycle, then 0; frame_error and overrun never pulse.
REQ-030: rx low for 4 cycles, then high -> START aborts at the half-bit check; busy returns to 0; no outputs change.
REQ-031: Send 8'h3C with stop bit driven 0 -> frame_error one-cycle pulse; data_valid stays 0; data_out unchanged.
REQ-032: Send 8'h11 then back-to-back 8'h22 without data_ready -> after the second stop, data_out = 8'h22, overrun one-cycle pulse, data_valid = 1.
REQ-033: Pull rst_n low during data bit 3 of 8'hFF, release with rx high, then send 8'h5A -> only 8'h5A is reported.
REQ-034: Send 8'h00 and 8'hFF -> data_out values exact; the all-zero byte is not flagged as a frame error.
